// File: rtl/apb_write_master.sv
// Purpose: queues write commands and plays each one out as an APB write (SETUP then ACCESS).
// Latency: psel rises 1 cycle after a push into an empty idle queue; a transfer takes 2 cycles plus pready wait states.
// Backpressure: cmd_ready drops while the queue is full; an ACCESS with no pready for TIMEOUT cycles is aborted.
//
// Ports:
//   pclk, presetn             clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_addr/cmd_wdata are the payload
//   psel/penable/pwrite       APB control, driven from the FSM state
//   paddr/pwdata              APB address/data, loaded from the queue head on SETUP entry
//   pready                    slave ready, sampled only in ACCESS
//   xfer_done/xfer_err        one-cycle completion / timeout-abort pulses
//   busy                      FSM active or commands still queued
//   xfer_count                completed transfers, wraps at 16 bits
module apb_write_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic              busy,
    output logic [15:0]       xfer_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int EW     = ADDR_W + DATA_W;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, next_state;

    // ------------------------------------------------------------------
    // Command queue: extra pointer bit distinguishes full from empty.
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Readiness looks only at the current fill level, so a pop in the same
    // cycle never lets a full queue take another command.
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    // The head is consumed exactly when the FSM moves into SETUP.
    assign pop        = (next_state == SETUP);
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // ACCESS wait-state counter; cleared on every SETUP entry.
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] wait_cnt;
    logic              done_evt;
    logic              timeout_evt;

    assign done_evt    = (state == ACCESS) && pready;
    // The last permitted ACCESS cycle is the one where wait_cnt = TIMEOUT-1,
    // so an unanswered transfer spends exactly TIMEOUT cycles in ACCESS.
    assign timeout_evt = (state == ACCESS) && !pready &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (pop) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready && !timeout_evt) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    next_state = fifo_empty ? IDLE : SETUP;
                end else if (timeout_evt) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        case (state)
            SETUP: begin
                psel   = 1'b1;
                pwrite = 1'b1;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = 1'b1;
            end
            default: begin
                psel    = 1'b0;
                penable = 1'b0;
                pwrite  = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Address/data hold registers and status
    // ------------------------------------------------------------------
    logic [15:0] xfer_count_q;

    // paddr/pwdata only change on SETUP entry, which keeps them stable across
    // the whole transfer and holds the last values while idle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= '0;
            pwdata <= '0;
        end else if (pop) begin
            paddr  <= head[EW-1:DATA_W];
            pwdata <= head[DATA_W-1:0];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            xfer_done    <= 1'b0;
            xfer_err     <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            xfer_done <= done_evt;
            xfer_err  <= timeout_evt;
            if (done_evt) begin
                xfer_count_q <= xfer_count_q + 16'd1;
            end
        end
    end

    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_apb_write_master.sv
// Purpose: directed self-checking bench for apb_write_master.
// Latency: inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
// Backpressure: the slave model is the pready input driven from the vectors and sequences.
module tb_apb_write_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    logic        pready;
    logic        xfer_done;
    logic        xfer_err;
    logic        busy;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    apb_write_master #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (4),
        .TIMEOUT(16)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .xfer_done (xfer_done),
        .xfer_err  (xfer_err),
        .busy      (busy),
        .xfer_count(xfer_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Outputs packed as {psel,penable,pwrite,paddr,pwdata,done,err,rdy,busy,count}.
    typedef struct {
        logic        v;
        logic [7:0]  a;
        logic [7:0]  d;
        logic        pr;
        logic [38:0] exp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic v, input logic [7:0] a, input logic [7:0] d,
                                input logic pr, input logic [2:0] ctl,
                                input logic [7:0] pa, input logic [7:0] pd,
                                input logic [3:0] flg, input logic [15:0] cnt);
        vec_t r;
        r.v   = v;
        r.a   = a;
        r.d   = d;
        r.pr  = pr;
        r.exp = {ctl, pa, pd, flg, cnt};
        return r;
    endfunction

    function automatic logic [38:0] outs();
        return {psel, penable, pwrite, paddr, pwdata,
                xfer_done, xfer_err, cmd_ready, busy, xfer_count};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample just after the rising edge.
    task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] d, input logic pr);
        @(negedge pclk);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_wdata = d;
        pready    = pr;
        @(posedge pclk);
        #1;
        check("done_err_exclusive", 64'(xfer_done & xfer_err), 64'd0);
    endtask

    // Watchdog: every wait is already bounded, this is a last resort.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        logic got_err;
        logic saw_done;
        logic unstable;
        logic any_psel;
        logic any_busy;

        // ---- vectors: single transfer, then queue-full with wait states ----
        //            v  addr   data   pr  ctl     paddr  pwdata flags    count
        vecs[0]  = mk(1, 8'h3C, 8'hA5, 1, 3'b000, 8'h00, 8'h00, 4'b0011, 16'd0);
        vecs[1]  = mk(0, 8'h00, 8'h00, 1, 3'b101, 8'h3C, 8'hA5, 4'b0011, 16'd0);
        vecs[2]  = mk(0, 8'h00, 8'h00, 1, 3'b111, 8'h3C, 8'hA5, 4'b0011, 16'd0);
        vecs[3]  = mk(0, 8'h00, 8'h00, 1, 3'b000, 8'h3C, 8'hA5, 4'b1010, 16'd1);
        vecs[4]  = mk(0, 8'h00, 8'h00, 1, 3'b000, 8'h3C, 8'hA5, 4'b0010, 16'd1);
        vecs[5]  = mk(1, 8'h11, 8'h21, 0, 3'b000, 8'h3C, 8'hA5, 4'b0011, 16'd1);
        vecs[6]  = mk(1, 8'h12, 8'h22, 0, 3'b101, 8'h11, 8'h21, 4'b0011, 16'd1);
        vecs[7]  = mk(1, 8'h13, 8'h23, 0, 3'b111, 8'h11, 8'h21, 4'b0011, 16'd1);
        vecs[8]  = mk(1, 8'h14, 8'h24, 0, 3'b111, 8'h11, 8'h21, 4'b0011, 16'd1);
        vecs[9]  = mk(1, 8'h15, 8'h25, 0, 3'b111, 8'h11, 8'h21, 4'b0001, 16'd1);
        vecs[10] = mk(1, 8'h16, 8'h26, 0, 3'b111, 8'h11, 8'h21, 4'b0001, 16'd1);
        vecs[11] = mk(1, 8'h16, 8'h26, 1, 3'b101, 8'h12, 8'h22, 4'b1011, 16'd2);
        vecs[12] = mk(0, 8'h00, 8'h00, 1, 3'b111, 8'h12, 8'h22, 4'b0011, 16'd2);
        vecs[13] = mk(0, 8'h00, 8'h00, 1, 3'b101, 8'h13, 8'h23, 4'b1011, 16'd3);
        vecs[14] = mk(0, 8'h00, 8'h00, 1, 3'b111, 8'h13, 8'h23, 4'b0011, 16'd3);
        vecs[15] = mk(0, 8'h00, 8'h00, 1, 3'b101, 8'h14, 8'h24, 4'b1011, 16'd4);
        vecs[16] = mk(0, 8'h00, 8'h00, 1, 3'b111, 8'h14, 8'h24, 4'b0011, 16'd4);
        vecs[17] = mk(0, 8'h00, 8'h00, 1, 3'b101, 8'h15, 8'h25, 4'b1011, 16'd5);
        vecs[18] = mk(0, 8'h00, 8'h00, 1, 3'b111, 8'h15, 8'h25, 4'b0011, 16'd5);
        vecs[19] = mk(0, 8'h00, 8'h00, 1, 3'b000, 8'h15, 8'h25, 4'b1010, 16'd6);
        vecs[20] = mk(0, 8'h00, 8'h00, 1, 3'b000, 8'h15, 8'h25, 4'b0010, 16'd6);

        // ---- reset ----
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        pready    = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        #1;
        check("reset_state", 64'(outs()), 64'({3'b000, 8'h00, 8'h00, 4'b0010, 16'd0}));

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].pr);
            check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
        end

        // ---- timeout: A never answered, B must still complete ----
        apply(1, 8'h40, 8'h50, 0);
        apply(1, 8'h41, 8'h51, 0);
        acc      = 0;
        got_err  = 1'b0;
        saw_done = 1'b0;
        unstable = 1'b0;
        for (int c = 0; c < 40 && !got_err; c++) begin
            apply(0, 8'h00, 8'h00, 0);
            if (psel && penable) begin
                acc++;
                if (paddr != 8'h40 || pwdata != 8'h50 || !pwrite) unstable = 1'b1;
            end
            if (xfer_done) saw_done = 1'b1;
            if (xfer_err)  got_err  = 1'b1;
        end
        check("timeout_err_seen", 64'(got_err), 64'd1);
        check("timeout_access_cycles", 64'(acc), 64'd16);
        check("timeout_addr_stable", 64'(unstable), 64'd0);
        check("timeout_no_done", 64'(saw_done), 64'd0);
        check("timeout_count_kept", 64'(xfer_count), 64'd6);
        check("timeout_state", 64'({psel, penable, busy}), 64'(3'b001));
        apply(0, 8'h00, 8'h00, 1);
        check("timeout_err_one_pulse", 64'(xfer_err), 64'd0);
        check("after_timeout_setup", 64'({psel, penable, paddr, pwdata}), 64'({2'b10, 8'h41, 8'h51}));
        saw_done = 1'b0;
        for (int c = 0; c < 10 && !saw_done; c++) begin
            apply(0, 8'h00, 8'h00, 1);
            if (xfer_done) saw_done = 1'b1;
        end
        check("after_timeout_done", 64'(saw_done), 64'd1);
        check("after_timeout_count", 64'({xfer_count, paddr, pwdata}), 64'({16'd7, 8'h41, 8'h51}));

        // ---- async reset during ACCESS with two commands queued ----
        apply(1, 8'h60, 8'h70, 0);
        apply(1, 8'h61, 8'h71, 0);
        apply(1, 8'h62, 8'h72, 0);
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("pre_reset_access", 64'({psel, penable, paddr}), 64'({2'b11, 8'h60}));
        #2;
        presetn = 1'b0;
        #1;
        check("reset_mid_outputs", 64'(outs()), 64'({3'b000, 8'h00, 8'h00, 4'b0010, 16'd0}));
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn  = 1'b1;
        any_psel = 1'b0;
        any_busy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            apply(0, 8'h00, 8'h00, 1);
            any_psel |= psel;
            any_busy |= busy;
        end
        check("reset_no_psel", 64'(any_psel), 64'd0);
        check("reset_no_busy", 64'(any_busy), 64'd0);
        check("reset_count_zero", 64'(xfer_count), 64'd0);

        // ---- counter wrap from 0xFFFF ----
        @(negedge pclk);
        force dut.xfer_count_q = 16'hFFFF;
        #1;
        release dut.xfer_count_q;
        apply(1, 8'h7E, 8'hE7, 1);
        apply(0, 8'h00, 8'h00, 1);
        apply(0, 8'h00, 8'h00, 1);
        apply(0, 8'h00, 8'h00, 1);
        check("wrap_done", 64'({xfer_done, paddr, pwdata}), 64'({1'b1, 8'h7E, 8'hE7}));
        check("wrap_count", 64'(xfer_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
